// File: rtl/pe_dot_engine.sv
// pe_dot_engine: signed dot product of two C-element vectors, P multiplies per
// cycle, with a full-precision result and a shifted/narrowed copy.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   accept handshake for the x/k/shift operands
//   x, k                signed operand vectors (C elements of W_X / W_K bits)
//   shift               right-shift amount applied to the result for y_out
//   out_valid/out_ready result handshake
//   y_out               acc >>> shift narrowed to W_X bits
//   acc_out             full-precision W_Y-bit dot product
//   busy                operation in flight (RUN or DONE)
//
// Build option: define PE_DOT_SAT_EN to saturate y_out instead of wrapping it.
module pe_dot_engine #(
  parameter int unsigned C   = 8,
  parameter int unsigned W_X = 8,
  parameter int unsigned W_K = 8,
  parameter int unsigned P   = 2,
  localparam int unsigned W_M = W_X + W_K,
  localparam int unsigned W_Y = W_M + $clog2(C),
  localparam int unsigned N   = C / P,
  localparam int unsigned W_S = $clog2(W_Y)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [C-1:0][W_X-1:0]       x,
  input  logic [C-1:0][W_K-1:0]       k,
  input  logic [W_S-1:0]              shift,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [W_X-1:0]       y_out,
  output logic signed [W_Y-1:0]       acc_out,
  output logic                        busy
);

  localparam int unsigned W_I = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned W_C = (C > 1) ? $clog2(C) : 1;

`ifdef PE_DOT_SAT_EN
  localparam logic signed [W_Y-1:0] Y_MAX = W_Y'((2 ** (W_X - 1)) - 1);
  localparam logic signed [W_Y-1:0] Y_MIN = ~Y_MAX;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [C-1:0][W_X-1:0]     x_q, x_d;
  logic [C-1:0][W_K-1:0]     k_q, k_d;
  logic [W_S-1:0]            shift_q, shift_d;
  logic signed [W_Y-1:0]     acc_q, acc_d;
  logic [W_I-1:0]            idx_q, idx_d;
  logic signed [W_X-1:0]     y_q, y_d;
  logic                      in_ready_q, in_ready_d;
  logic                      out_valid_q, out_valid_d;
  logic                      busy_q, busy_d;

  logic [W_C-1:0]            elem;
  logic signed [W_M-1:0]     x_ext, k_ext, prod;
  logic signed [W_Y-1:0]     beat_sum, acc_next, shifted;
  logic signed [W_X-1:0]     y_narrow;
  int unsigned               sh_eff;

  // Next-state, datapath and output-flag computation.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    k_d         = k_q;
    shift_d     = shift_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    y_d         = y_q;
    elem        = '0;
    x_ext       = '0;
    k_ext       = '0;
    prod        = '0;
    beat_sum    = '0;

    // Sum of the P products belonging to the current beat.
    for (int i = 0; i < int'(P); i++) begin
      elem     = W_C'(int'(idx_q) * int'(P) + i);
      x_ext    = W_M'($signed(x_q[elem]));
      k_ext    = W_M'($signed(k_q[elem]));
      prod     = x_ext * k_ext;
      beat_sum = beat_sum + W_Y'(prod);
    end
    acc_next = acc_q + beat_sum;

    // Shifts beyond the accumulator width collapse to a sign fill.
    sh_eff  = (int'(shift_q) >= int'(W_Y)) ? (W_Y - 1) : int'(shift_q);
    shifted = acc_next >>> sh_eff;

`ifdef PE_DOT_SAT_EN
    if (shifted > Y_MAX) begin
      y_narrow = W_X'(Y_MAX);
    end else if (shifted < Y_MIN) begin
      y_narrow = W_X'(Y_MIN);
    end else begin
      y_narrow = W_X'(shifted);
    end
`else
    y_narrow = W_X'(shifted);
`endif

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = x;
          k_d     = k;
          shift_d = shift;
          acc_d   = '0;
          idx_d   = '0;
          y_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_next;
        idx_d = idx_q + W_I'(1);
        if (idx_q == W_I'(N - 1)) begin
          idx_d   = '0;
          y_d     = y_narrow;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      k_q         <= '0;
      shift_q     <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      y_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      k_q         <= k_d;
      shift_q     <= shift_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      y_q         <= y_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign acc_out   = acc_q;
  assign y_out     = y_q;

endmodule

// File: tb/tb_pe_dot_engine.sv
// Testbench for pe_dot_engine at the default configuration (C=8, P=2, 8-bit
// operands). Directed cases plus random vectors checked against an integer
// reference model of the dot product, shift and narrowing.
module tb_pe_dot_engine;

  localparam int C   = 8;
  localparam int W_X = 8;
  localparam int W_K = 8;
  localparam int P   = 2;
  localparam int N   = C / P;
  localparam int W_Y = W_X + W_K + $clog2(C);
  localparam int W_S = $clog2(W_Y);

  typedef int vec_t [C];

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic [C-1:0][W_X-1:0]   x;
  logic [C-1:0][W_K-1:0]   k;
  logic [W_S-1:0]          shift;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [W_X-1:0]   y_out;
  logic signed [W_Y-1:0]   acc_out;
  logic                    busy;

  int checks = 0;
  int errors = 0;

  pe_dot_engine #(.C(C), .W_X(W_X), .W_K(W_K), .P(P)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .k         (k),
    .shift     (shift),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y_out     (y_out),
    .acc_out   (acc_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: plain integer dot product.
  function automatic int model_acc(input vec_t xa, input vec_t ka);
    int s = 0;
    for (int i = 0; i < C; i++) s += xa[i] * ka[i];
    return s;
  endfunction

  // Reference: floor shift with clamp, then saturate or wrap to W_X bits.
  function automatic int model_y(input int acc, input int sh);
    int s;
    int v;
    s = (sh >= W_Y) ? W_Y - 1 : sh;
    v = acc >>> s;
`ifdef PE_DOT_SAT_EN
    if (v > 127) v = 127;
    if (v < -128) v = -128;
`else
    v = v & 255;
    if (v >= 128) v -= 256;
`endif
    return v;
  endfunction

  function automatic int rand_elem();
    case ($urandom_range(0, 3))
      0:       return -128;
      1:       return 127;
      default: return int'($urandom_range(0, 255)) - 128;
    endcase
  endfunction

  task automatic drive_vec(input vec_t xa, input vec_t ka, input int sh);
    for (int i = 0; i < C; i++) begin
      x[i] = W_X'(xa[i]);
      k[i] = W_K'(ka[i]);
    end
    shift = W_S'(sh);
  endtask

  task automatic scramble();
    for (int i = 0; i < C; i++) begin
      x[i] = W_X'($urandom);
      k[i] = W_K'($urandom);
    end
    shift = W_S'($urandom);
  endtask

  // One transaction from IDLE: accept, wait for the result, hold out_ready low
  // for 'hold' cycles, then hand shake. Inputs are scrambled and in_valid kept
  // high after accept to show they are ignored.
  task automatic run_vec(input string tag, input vec_t xa, input vec_t ka,
                         input int sh, input int hold, input bit use_lit,
                         input int lit_acc, input int lit_y);
    int n;
    int ea;
    int ey;
    ea = use_lit ? lit_acc : model_acc(xa, ka);
    ey = use_lit ? lit_y : model_y(model_acc(xa, ka), sh);
    check({tag, ".in_ready_idle"}, int'(in_ready), 1);
    drive_vec(xa, ka, sh);
    in_valid = 1'b1;
    @(negedge clk);
    scramble();
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    check({tag, ".latency"}, n, N);
    check({tag, ".acc_out"}, int'(acc_out), ea);
    check({tag, ".y_out"}, int'(y_out), ey);
    check({tag, ".in_ready_done"}, int'(in_ready), 0);
    check({tag, ".busy_done"}, int'(busy), 1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, ".hold_valid"}, int'(out_valid), 1);
      check({tag, ".hold_acc"}, int'(acc_out), ea);
      check({tag, ".hold_y"}, int'(y_out), ey);
      check({tag, ".hold_in_ready"}, int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".post_valid"}, int'(out_valid), 0);
    check({tag, ".post_in_ready"}, int'(in_ready), 1);
    check({tag, ".post_busy"}, int'(busy), 0);
  endtask

  initial begin
    vec_t xa;
    vec_t ka;
    vec_t xb;
    vec_t kb;
    int   n;
    int   seen;
    int   ea;
    int   eb;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x         = '0;
    k         = '0;
    shift     = '0;
    repeat (2) @(negedge clk);
    check("reset.in_ready", int'(in_ready), 1);
    check("reset.out_valid", int'(out_valid), 0);
    check("reset.busy", int'(busy), 0);
    check("reset.acc_out", int'(acc_out), 0);
    check("reset.y_out", int'(y_out), 0);
    rst = 1'b0;
    @(negedge clk);

    // x all 1, k = 1..8
    for (int i = 0; i < C; i++) begin xa[i] = 1; ka[i] = i + 1; end
    run_vec("ones", xa, ka, 0, 0, 1'b1, 36, 36);

    // x all -1, k = 1..8, shift 2, with a 5-cycle output stall
    for (int i = 0; i < C; i++) begin xa[i] = -1; ka[i] = i + 1; end
    run_vec("neg_stall", xa, ka, 2, 5, 1'b1, -36, -9);

    // Extreme operands: the largest possible accumulator value
    for (int i = 0; i < C; i++) begin xa[i] = -128; ka[i] = -128; end
`ifdef PE_DOT_SAT_EN
    run_vec("max_sh0", xa, ka, 0, 0, 1'b1, 131072, 127);
    run_vec("max_sh10", xa, ka, 10, 0, 1'b1, 131072, 127);
`else
    run_vec("max_sh0", xa, ka, 0, 0, 1'b1, 131072, 0);
    run_vec("max_sh10", xa, ka, 10, 0, 1'b1, 131072, -128);
`endif
    // Shift at and beyond the clamp point
    run_vec("max_sh31", xa, ka, 31, 0, 1'b0, 0, 0);
    for (int i = 0; i < C; i++) begin xa[i] = -128; ka[i] = 127; end
    run_vec("min_sh19", xa, ka, 19, 1, 1'b0, 0, 0);

    // Back-to-back: in_valid held high across two vector pairs
    for (int i = 0; i < C; i++) begin
      xa[i] = rand_elem(); ka[i] = rand_elem();
      xb[i] = rand_elem(); kb[i] = rand_elem();
    end
    ea = model_acc(xa, ka);
    eb = model_acc(xb, kb);
    drive_vec(xa, ka, 3);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    drive_vec(xb, kb, 5);
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    check("b2b.a_latency", n, N);
    check("b2b.a_acc", int'(acc_out), ea);
    check("b2b.a_y", int'(y_out), model_y(ea, 3));
    @(negedge clk);
    check("b2b.gap_valid", int'(out_valid), 0);
    check("b2b.gap_in_ready", int'(in_ready), 1);
    @(negedge clk);
    check("b2b.b_accepted", int'(in_ready), 0);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    check("b2b.b_latency", n, N);
    check("b2b.b_acc", int'(acc_out), eb);
    check("b2b.b_y", int'(y_out), model_y(eb, 5));
    @(negedge clk);
    out_ready = 1'b0;
    check("b2b.end_valid", int'(out_valid), 0);

    // Reset on the second RUN cycle aborts without a result
    for (int i = 0; i < C; i++) begin xa[i] = rand_elem(); ka[i] = rand_elem(); end
    drive_vec(xa, ka, 0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst       = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b0;
    check("abort.busy", int'(busy), 0);
    check("abort.in_ready", int'(in_ready), 1);
    check("abort.acc_out", int'(acc_out), 0);
    check("abort.out_valid", int'(out_valid), 0);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("abort.no_pulse", seen, 0);
    run_vec("after_abort", xa, ka, 4, 0, 1'b0, 0, 0);

    // Random vectors and shifts
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < C; i++) begin xa[i] = rand_elem(); ka[i] = rand_elem(); end
      run_vec($sformatf("rand%0d", t), xa, ka, int'($urandom_range(0, 31)),
              int'($urandom_range(0, 2)), 1'b0, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
